run_dump_ctrl: RTL and testbench

RUN_DUMP_CTRL -- requirements
Module: run_dump_ctrl

---
 rtl/run_dump_ctrl.sv | 133 +++++++++++++
 tb/tb_run_dump_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_dump_ctrl.sv
// run_dump_ctrl: lets the CPU run for a fixed number of cycles after reset,
// then halts it and streams out the register file (R0..R31) followed by two
// data-memory words over a valid/ready channel, ending in a terminal DONE.
module run_dump_ctrl #(
  parameter int HALT_CYCLES = 40,
  parameter int DM_ADDR0    = 80,
  parameter int DM_ADDR1    = 84
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cpu_halt,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [29:0] dm_raddr,
  input  logic [31:0] dm_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_tag,
  output logic        done
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] HALT_LAST = 16'(HALT_CYCLES - 1);
  localparam logic [29:0] DM_WORD0  = 30'(DM_ADDR0 >> 2);
  localparam logic [29:0] DM_WORD1  = 30'(DM_ADDR1 >> 2);
  localparam logic [5:0]  IDX_END   = 6'd34;

  state_t      state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [5:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [7:0]  out_tag_q, out_tag_d;

  logic        load;
  logic [31:0] word_sel;
  logic [7:0]  tag_sel;

  assign cpu_halt  = (state_q != RUN);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

  // Read addresses follow idx; DM port parks on the first dump word.
  always_comb begin
    rf_raddr = 5'd0;
    dm_raddr = DM_WORD0;
    if (idx_q < 6'd32) rf_raddr = idx_q[4:0];
    if (idx_q == 6'd33) dm_raddr = DM_WORD1;
  end

  // Pick the word and tag that the next load would capture (R0 forced to zero).
  always_comb begin
    word_sel = 32'd0;
    tag_sel  = 8'h00;
    if (idx_q == 6'd0) begin
      word_sel = 32'd0;
      tag_sel  = 8'h00;
    end else if (idx_q < 6'd32) begin
      word_sel = rf_rdata;
      tag_sel  = {3'b000, idx_q[4:0]};
    end else if (idx_q == 6'd32) begin
      word_sel = dm_rdata;
      tag_sel  = 8'h80;
    end else begin
      word_sel = dm_rdata;
      tag_sel  = 8'h81;
    end
  end

  // Next-state logic: run countdown, dump sequencing with output-register load.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    load        = (state_q == DUMP) && (!out_valid_q || out_ready);
    case (state_q)
      RUN: begin
        cyc_d = cyc_q + 16'd1;
        if (cyc_q == HALT_LAST) state_d = DUMP;
      end
      DUMP: begin
        if (load) begin
          if (idx_q < IDX_END) begin
            out_data_d  = word_sel;
            out_tag_d   = tag_sel;
            out_valid_d = 1'b1;
            idx_d       = idx_q + 6'd1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        out_valid_d = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cyc_q       <= 16'd0;
      idx_q       <= 6'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_tag_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Directed bench for run_dump_ctrl: run window length, full dump with and
// without back-pressure, mid-dump reset, R0 forcing, and HALT_CYCLES=1 stall.
module tb_run_dump_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst, out_ready, cpu_halt, out_valid, done;
  logic [4:0]  rf_raddr;
  logic [29:0] dm_raddr;
  logic [31:0] rf_rdata, dm_rdata, out_data;
  logic [7:0]  out_tag;
  logic        r0_ones;

  // HALT_CYCLES=1 instance
  logic        rst1, out_ready1, cpu_halt1, out_valid1, done1;
  logic [4:0]  rf_raddr1;
  logic [29:0] dm_raddr1;
  logic [31:0] rf_rdata1, dm_rdata1, out_data1;
  logic [7:0]  out_tag1;

  int n_total = 0;
  int n_bad   = 0;

  function automatic logic [31:0] rf_model(logic [4:0] a, logic ones);
    if (ones && a == 5'd0) return 32'hFFFF_FFFF;
    return 32'(a) * 32'h11;
  endfunction

  function automatic logic [31:0] dm_model(logic [29:0] a);
    if (a == 30'd20) return 32'd7;
    if (a == 30'd21) return 32'd9;
    return 32'hDEAD_0000 | 32'(a);
  endfunction

  function automatic logic [31:0] exp_data(int k);
    if (k == 0) return 32'd0;
    if (k < 32) return 32'(k) * 32'h11;
    if (k == 32) return 32'd7;
    return 32'd9;
  endfunction

  function automatic logic [31:0] exp_tag(int k);
    if (k < 32) return 32'(k);
    return 32'h80 + 32'(k - 32);
  endfunction

  assign rf_rdata  = rf_model(rf_raddr, r0_ones);
  assign dm_rdata  = dm_model(dm_raddr);
  assign rf_rdata1 = rf_model(rf_raddr1, 1'b0);
  assign dm_rdata1 = dm_model(dm_raddr1);

  run_dump_ctrl u_dut (
    .clk(clk), .rst(rst), .cpu_halt(cpu_halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .done(done)
  );

  run_dump_ctrl #(.HALT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1), .cpu_halt(cpu_halt1),
    .rf_raddr(rf_raddr1), .rf_rdata(rf_rdata1),
    .dm_raddr(dm_raddr1), .dm_rdata(dm_rdata1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_tag(out_tag1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_to_halt(output int edges);
    edges = 0;
    while (!cpu_halt && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  int edges, k, cyc;
  logic [31:0] last_data;
  logic [7:0]  last_tag;
  logic        stalled;
  logic [3:0]  pat;

  initial begin
    rst = 1'b1; out_ready = 1'b0; r0_ones = 1'b0;
    rst1 = 1'b1; out_ready1 = 1'b0;
    pat = 4'b1001;

    // Reset state
    do_reset();
    chk("rst_halt", 32'(cpu_halt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_rfaddr", 32'(rf_raddr), 32'd0);
    chk("rst_dmaddr", 32'(dm_raddr), 32'd20);
    $display("reset checked");

    // Run window: halt rises exactly on edge 40
    out_ready = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      chk($sformatf("run_halt_e%0d", e), 32'(cpu_halt), (e < 40) ? 32'd0 : 32'd1);
      if (e < 40) chk($sformatf("run_valid_e%0d", e), 32'(out_valid), 32'd0);
    end
    $display("run window: halt after edge 40");

    // Full dump, ready held high: 34 consecutive words
    for (int i = 0; i < 34; i++) begin
      tick();
      chk($sformatf("d1_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("d1_tag_%0d", i), 32'(out_tag), exp_tag(i));
      chk($sformatf("d1_data_%0d", i), out_data, exp_data(i));
      $display("dump1 word %0d tag=0x%02h data=0x%08h", i, out_tag, out_data);
    end
    tick();
    chk("d1_end_valid", 32'(out_valid), 32'd0);
    chk("d1_end_done", 32'(done), 32'd1);
    chk("d1_end_halt", 32'(cpu_halt), 32'd1);
    out_ready = 1'b0;
    tick(); tick();
    chk("d1_done_hold", 32'(done), 32'd1);
    chk("d1_done_valid", 32'(out_valid), 32'd0);

    // Back-pressured dump with R0 reading all-ones
    r0_ones = 1'b1;
    out_ready = 1'b0;
    do_reset();
    run_to_halt(edges);
    chk("d2_run_edges", 32'(edges), 32'd40);
    k = 0; cyc = 0; stalled = 1'b0; last_data = '0; last_tag = '0;
    while (!done && cyc < 400) begin
      if (out_valid) begin
        if (stalled) begin
          chk($sformatf("d2_stable_tag_%0d", k), 32'(out_tag), 32'(last_tag));
          chk($sformatf("d2_stable_data_%0d", k), out_data, last_data);
        end
        chk($sformatf("d2_tag_%0d", k), 32'(out_tag), exp_tag(k));
        chk($sformatf("d2_data_%0d", k), out_data, exp_data(k));
        last_tag = out_tag;
        last_data = out_data;
      end
      out_ready = (cyc < 8) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
      stalled = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        $display("dump2 word %0d tag=0x%02h data=0x%08h", k, out_tag, out_data);
        k++;
      end
      tick();
      cyc++;
    end
    chk("d2_count", 32'(k), 32'd34);
    chk("d2_done", 32'(done), 32'd1);
    r0_ones = 1'b0;

    // Reset after the 10th transfer, then a fresh run and dump
    out_ready = 1'b1;
    do_reset();
    run_to_halt(edges);
    cyc = 0;
    while (!(out_valid && out_tag == 8'h0A) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("d3_reach_10", 32'(out_tag), 32'h0A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("d3_rst_valid", 32'(out_valid), 32'd0);
    chk("d3_rst_halt", 32'(cpu_halt), 32'd0);
    chk("d3_rst_done", 32'(done), 32'd0);
    $display("reset mid-dump applied");
    run_to_halt(edges);
    chk("d3_run_edges", 32'(edges), 32'd40);
    tick();
    chk("d3_first_valid", 32'(out_valid), 32'd1);
    chk("d3_first_tag", 32'(out_tag), 32'h00);
    $display("redump first tag=0x%02h", out_tag);

    // HALT_CYCLES=1 with consumer stalled
    out_ready1 = 1'b0;
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk("h1_rst_halt", 32'(cpu_halt1), 32'd0);
    tick();
    chk("h1_halt_after1", 32'(cpu_halt1), 32'd1);
    chk("h1_valid_pre", 32'(out_valid1), 32'd0);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk($sformatf("h1_valid_%0d", s), 32'(out_valid1), 32'd1);
      chk($sformatf("h1_tag_%0d", s), 32'(out_tag1), 32'h00);
      chk($sformatf("h1_data_%0d", s), out_data1, 32'd0);
      chk($sformatf("h1_idx_%0d", s), 32'(rf_raddr1), 32'd1);
      $display("h1 stall cycle %0d tag=0x%02h", s, out_tag1);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    chk("h1_next_tag", 32'(out_tag1), 32'h01);
    chk("h1_next_data", out_data1, 32'h11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
